alu_design: RTL and testbench
=============================

Name: alu_design

Overview:
- Registered 8-bit ALU with arithmetic and logical command sets, per-operand valid qualifiers, clock enable, and comparison, carry, overflow and error flags.
- Leaf datapath block. Driven by the ALU verification interface (alu_intf) and monitored by a protocol/result assertion checker bound on its ports.
- Not pipelined, except for a two-cycle multiply path.

Parameters:
- WIDTH, 8, operand width of OPA/OPB.
- CMD_WIDTH, 4, width of CMD.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- OPA  in  WIDTH  operand A
- OPB  in  WIDTH  operand B
- CIN  in  1  carry/borrow in for ADD_CIN/SUB_CIN
- CE  in  1  clock enable; 0 freezes all outputs and internal state
- MODE  in  1  1 = arithmetic set, 0 = logical set
- CMD  in  CMD_WIDTH  command code
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- RES  out  2*WIDTH  result, zero-extended
- COUT  out  1  carry out
- OFLOW  out  1  overflow/borrow
- G, L, E  out  1 each  compare flags A>B, A<B, A==B
- ERR  out  1  error flag

Behaviour:
- Reset: RST=1 at a rising edge clears all outputs and the multiply stage to 0. Reset has priority over CE and an in-flight multiply.
- Inputs are sampled at a rising edge with CE=1. Outputs update at that same edge, giving 1-cycle latency.
- Every update recomputes all outputs. Any flag not defined for the command is driven 0.
- Arithmetic set (MODE=1); "need" gives the required INP_VALID:
  - 0 ADD, need 11: RES=A+B, COUT=bit WIDTH of sum.
  - 1 SUB, need 11: RES=A-B (WIDTH bits), OFLOW=(A<B).
  - 2 ADD_CIN, need 11: RES=A+B+CIN, COUT=bit WIDTH of sum.
  - 3 SUB_CIN, need 11: RES=A-B-CIN (WIDTH bits), OFLOW=(A<B+CIN).
  - 4 INC_A, need 01: RES=A+1 in WIDTH+1 bits.
  - 5 DEC_A, need 01: RES=A-1 in WIDTH bits.
  - 6 INC_B, need 10: RES=B+1 in WIDTH+1 bits.
  - 7 DEC_B, need 10: RES=B-1 in WIDTH bits.
  - 8 CMP, need 11: RES=0, exactly one of G/L/E set.
  - 9 MUL_INC, need 11: RES=(A+1)*(B+1).
  - 10 MUL_SHL, need 11: RES=((A<<1) mod 2^WIDTH)*B.
- Logical set (MODE=0); results are WIDTH bits, zero-extended in RES:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR: need 11.
  - 6 NOT_A: need 01.
  - 7 NOT_B: need 10.
  - 8 SHR1_A, 9 SHL1_A: need 01.
  - 10 SHR1_B, 11 SHL1_B: need 10.
  - 12 ROL_A_B: A rotated left by B[2:0]; need 11.
  - 13 ROR_A_B: A rotated right by B[2:0]; need 11.
- Operand validity: an operand-A-only command also accepts INP_VALID=11; an operand-B-only command also accepts 11.
- ERR=1 with RES and all other flags 0 when any of these holds:
  - INP_VALID does not satisfy the command's need (includes 00 for every command);
  - CMD is undefined for the MODE (arith 11-15, logic 14-15).
- Rotate range check: ROL/ROR with B[WIDTH-1:3]!=0 produces the normal rotate result and also sets ERR=1.
- Wrap-around: INC_A of 0xFF gives RES=0x100. DEC_A of 0x00 gives RES=0xFF. Shifts discard the bit shifted out.
- Multiply path (CMD 9/10, MODE=1, valid operands):
  - Product is computed in cycle 1 and presented on RES at the second rising edge with CE=1.
  - Outputs hold their previous values at the first edge.
  - Inputs at the intermediate edge are ignored; the command is not queued.
  - CE=0 stalls the multiply stage.
  - An error during a multiply command reports after 1 cycle, like any other command, and never enters the multiply stage.
- CE low mid-multiply: state frozen, completes once CE returns high.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and CMD_WIDTH defaults;
  - enums for arithmetic and logical command codes;
  - the INP_VALID encoding constants (NONE=00, A=01, B=10, AB=11).
- Comparison and combinational result logic stay in alu_design.
- One natural sub-module is alu_mul_stage, the two-cycle multiply register stage with CE stall and synchronous reset.

Test Plan:
- Reset then ADD: RST=1 for 1 edge → all outputs 0. Then CE=1, MODE=1, CMD=0, A=0xFF, B=0x01, INP_VALID=11 → next edge RES=0x100, COUT=1, ERR=0.
- SUB borrow and CMP:
  - A=0x05, B=0x0A, CMD=1 → RES=0xFB, OFLOW=1.
  - CMD=8 with A=B=0x33 → E=1, G=L=0, RES=0.
- Multiply latency: CMD=9, A=0x03, B=0x04 → RES unchanged after edge 1, RES=0x14 after edge 2. CMD=10, A=0x81, B=0x02 → RES=0x04.
- Logical set: MODE=0.
  - CMD=1, A=0xF0, B=0xFF → RES=0x0F.
  - CMD=12, A=0x81, B=0x01 → RES=0x03, ERR=0.
  - CMD=13, B=0x10 → rotated result, ERR=1.
- Validity and illegal commands: INP_VALID=01 with ADD → ERR=1, RES=0. INP_VALID=01 with INC_A, A=0xFF → RES=0x100. MODE=0, CMD=15 → ERR=1.
- CE and reset mid-operation: CE=0 while inputs change → outputs hold. RST=1 during a multiply → all outputs 0 next edge, no late product.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU.
package alu_pkg;

    localparam int unsigned AluWidth    = 8;
    localparam int unsigned AluCmdWidth = 4;

    // Arithmetic command set (MODE=1).
    typedef enum logic [3:0] {
        CmdAdd    = 4'd0,
        CmdSub    = 4'd1,
        CmdAddCin = 4'd2,
        CmdSubCin = 4'd3,
        CmdIncA   = 4'd4,
        CmdDecA   = 4'd5,
        CmdIncB   = 4'd6,
        CmdDecB   = 4'd7,
        CmdCmp    = 4'd8,
        CmdMulInc = 4'd9,
        CmdMulShl = 4'd10
    } arith_cmd_e;

    // Logical command set (MODE=0).
    typedef enum logic [3:0] {
        CmdAnd    = 4'd0,
        CmdNand   = 4'd1,
        CmdOr     = 4'd2,
        CmdNor    = 4'd3,
        CmdXor    = 4'd4,
        CmdXnor   = 4'd5,
        CmdNotA   = 4'd6,
        CmdNotB   = 4'd7,
        CmdShr1A  = 4'd8,
        CmdShl1A  = 4'd9,
        CmdShr1B  = 4'd10,
        CmdShl1B  = 4'd11,
        CmdRolAB  = 4'd12,
        CmdRorAB  = 4'd13
    } logic_cmd_e;

    // INP_VALID encoding: bit0 = A valid, bit1 = B valid.
    localparam logic [1:0] InpNone = 2'b00;
    localparam logic [1:0] InpA    = 2'b01;
    localparam logic [1:0] InpB    = 2'b10;
    localparam logic [1:0] InpAB   = 2'b11;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic g;
        logic l;
        logic e;
        logic err;
    } alu_flags_t;

    // A single-operand command is also satisfied when both operands are valid.
    function automatic logic valid_ok(logic [1:0] inp_valid, logic [1:0] need);
        return (need != InpNone) && ((inp_valid & need) == need);
    endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// Two-cycle multiply register stage: captures the product on start, then
// flags it ready for exactly one CE-qualified edge.
module alu_mul_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = AluWidth
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ce_i,
    input  logic               start_i,
    input  logic               shl_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               busy_o,
    output logic [2*WIDTH-1:0] product_o
);

    logic               busy_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] a_ext, b_ext, a_shl;

    // Product of the selected multiply flavour, truncated to 2*WIDTH bits.
    always_comb begin
        a_ext = (2*WIDTH)'(opa_i);
        b_ext = (2*WIDTH)'(opb_i);
        a_shl = (2*WIDTH)'({opa_i[WIDTH-2:0], 1'b0});
        if (shl_i) begin
            prod_d = a_shl * b_ext;
        end else begin
            prod_d = (a_ext + 1'b1) * (b_ext + 1'b1);
        end
    end

    // Stage register; CE low freezes both the busy bit and the product.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            prod_q <= '0;
        end else if (ce_i) begin
            if (busy_q) begin
                busy_q <= 1'b0;
            end else if (start_i) begin
                busy_q <= 1'b1;
                prod_q <= prod_d;
            end
        end
    end

    assign busy_o    = busy_q;
    assign product_o = prod_q;

endmodule

// File: rtl/alu_design.sv
// Registered 8-bit ALU with arithmetic/logical command sets, operand valid
// qualifiers, clock enable and a two-cycle multiply path.
module alu_design
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = AluWidth,
    parameter int unsigned CMD_WIDTH = AluCmdWidth
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 L,
    output logic                 E,
    output logic                 ERR
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] res_q, res_d, res_calc;
    alu_flags_t         flags_q, flags_d, flags_calc;
    logic [1:0]         need;
    logic               cmd_ok, valid, range_err, is_mul, mul_req, mul_start;
    logic               mul_busy;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_sum, addc_sum, inc_a, inc_b;
    logic [WIDTH-1:0]   sub_d, subc_d, dec_a, dec_b, logic_res, rol_res, ror_res;
    logic               subc_borrow;
    logic [ShW-1:0]     rot_sh;
    logic [2*WIDTH-1:0] rol_dbl, ror_dbl;

    // Shared arithmetic and rotate datapath terms.
    always_comb begin
        add_sum     = {1'b0, OPA} + {1'b0, OPB};
        addc_sum    = add_sum + (WIDTH+1)'(CIN);
        sub_d       = OPA - OPB;
        subc_d      = OPA - OPB - WIDTH'(CIN);
        subc_borrow = {1'b0, OPA} < ({1'b0, OPB} + (WIDTH+1)'(CIN));
        inc_a       = {1'b0, OPA} + 1'b1;
        inc_b       = {1'b0, OPB} + 1'b1;
        dec_a       = OPA - 1'b1;
        dec_b       = OPB - 1'b1;
        rot_sh      = OPB[ShW-1:0];
        rol_dbl     = {OPA, OPA} << rot_sh;
        ror_dbl     = {OPA, OPA} >> rot_sh;
        rol_res     = rol_dbl[2*WIDTH-1:WIDTH];
        ror_res     = ror_dbl[WIDTH-1:0];
    end

    // Command decode, operand requirement and error/result selection.
    always_comb begin
        res_calc   = '0;
        flags_calc = '0;
        logic_res  = '0;
        need       = InpAB;
        cmd_ok     = 1'b1;
        range_err  = 1'b0;
        is_mul     = 1'b0;
        if (MODE) begin
            case (CMD)
                CmdAdd: begin
                    res_calc        = {{(WIDTH-1){1'b0}}, add_sum};
                    flags_calc.cout = add_sum[WIDTH];
                end
                CmdSub: begin
                    res_calc         = {{WIDTH{1'b0}}, sub_d};
                    flags_calc.oflow = OPA < OPB;
                end
                CmdAddCin: begin
                    res_calc        = {{(WIDTH-1){1'b0}}, addc_sum};
                    flags_calc.cout = addc_sum[WIDTH];
                end
                CmdSubCin: begin
                    res_calc         = {{WIDTH{1'b0}}, subc_d};
                    flags_calc.oflow = subc_borrow;
                end
                CmdIncA: begin
                    need     = InpA;
                    res_calc = {{(WIDTH-1){1'b0}}, inc_a};
                end
                CmdDecA: begin
                    need     = InpA;
                    res_calc = {{WIDTH{1'b0}}, dec_a};
                end
                CmdIncB: begin
                    need     = InpB;
                    res_calc = {{(WIDTH-1){1'b0}}, inc_b};
                end
                CmdDecB: begin
                    need     = InpB;
                    res_calc = {{WIDTH{1'b0}}, dec_b};
                end
                CmdCmp: begin
                    flags_calc.g = OPA > OPB;
                    flags_calc.l = OPA < OPB;
                    flags_calc.e = OPA == OPB;
                end
                CmdMulInc, CmdMulShl: is_mul = 1'b1;
                default: cmd_ok = 1'b0;
            endcase
        end else begin
            case (CMD)
                CmdAnd:   logic_res = OPA & OPB;
                CmdNand:  logic_res = ~(OPA & OPB);
                CmdOr:    logic_res = OPA | OPB;
                CmdNor:   logic_res = ~(OPA | OPB);
                CmdXor:   logic_res = OPA ^ OPB;
                CmdXnor:  logic_res = ~(OPA ^ OPB);
                CmdNotA:  begin need = InpA; logic_res = ~OPA;      end
                CmdNotB:  begin need = InpB; logic_res = ~OPB;      end
                CmdShr1A: begin need = InpA; logic_res = OPA >> 1;  end
                CmdShl1A: begin need = InpA; logic_res = OPA << 1;  end
                CmdShr1B: begin need = InpB; logic_res = OPB >> 1;  end
                CmdShl1B: begin need = InpB; logic_res = OPB << 1;  end
                CmdRolAB: begin
                    logic_res = rol_res;
                    range_err = |OPB[WIDTH-1:ShW];
                end
                CmdRorAB: begin
                    logic_res = ror_res;
                    range_err = |OPB[WIDTH-1:ShW];
                end
                default: cmd_ok = 1'b0;
            endcase
            res_calc = {{WIDTH{1'b0}}, logic_res};
        end

        valid   = valid_ok(INP_VALID, need);
        mul_req = is_mul & cmd_ok & valid;

        // Errors zero the result; an out-of-range rotate keeps its result.
        if (!cmd_ok || !valid) begin
            res_d       = '0;
            flags_d     = '0;
            flags_d.err = 1'b1;
        end else begin
            res_d       = res_calc;
            flags_d     = flags_calc;
            flags_d.err = range_err;
        end
    end

    // A new multiply is only accepted when the stage is idle.
    assign mul_start = mul_req & ~mul_busy;

    alu_mul_stage #(
        .WIDTH (WIDTH)
    ) u_mul_stage (
        .clk_i     (CLK),
        .rst_i     (RST),
        .ce_i      (CE),
        .start_i   (mul_start),
        .shl_i     (CMD == CMD_WIDTH'(CmdMulShl)),
        .opa_i     (OPA),
        .opb_i     (OPB),
        .busy_o    (mul_busy),
        .product_o (mul_product)
    );

    // Output registers: product when the multiply completes, hold on its
    // first edge, otherwise the freshly computed result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (CE) begin
            if (mul_busy) begin
                res_q   <= mul_product;
                flags_q <= '0;
            end else if (!mul_start) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign RES   = res_q;
    assign COUT  = flags_q.cout;
    assign OFLOW = flags_q.oflow;
    assign G     = flags_q.g;
    assign L     = flags_q.l;
    assign E     = flags_q.e;
    assign ERR   = flags_q.err;

endmodule

// File: tb/tb_alu_design.sv
// Directed self-checking bench for alu_design.
module tb_alu_design;

    logic        CLK = 1'b0;
    logic        RST, CIN, CE, MODE;
    logic [7:0]  OPA, OPB;
    logic [3:0]  CMD;
    logic [1:0]  INP_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, L, E, ERR;
    logic [21:0] outs;

    int passed = 0;
    int total  = 0;

    // Output vector: {RES, COUT, OFLOW, G, L, E, ERR}
    assign outs = {RES, COUT, OFLOW, G, L, E, ERR};

    always #5 CLK = ~CLK;

    alu_design dut (
        .CLK       (CLK),
        .RST       (RST),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] iv);
        MODE = m; CMD = c; OPA = a; OPB = b; INP_VALID = iv;
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b1;
        drive(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11);
        tick();
        total++;
        if (outs !== 22'h0) $display("FAIL reset: got %h want %h", outs, 22'h0);
        else passed++;
        RST = 1'b0;
    endtask

    task automatic test_arith();
        drive(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11); tick();
        total++;
        if (outs !== {16'h0100, 6'b100000}) $display("FAIL add: got %h want %h", outs, {16'h0100, 6'b100000});
        else passed++;

        CIN = 1'b1;
        drive(1'b1, 4'd2, 8'h10, 8'h20, 2'b11); tick();
        total++;
        if (outs !== {16'h0031, 6'b000000}) $display("FAIL add_cin: got %h want %h", outs, {16'h0031, 6'b000000});
        else passed++;

        drive(1'b1, 4'd3, 8'h05, 8'h05, 2'b11); tick();
        total++;
        if (outs !== {16'h00FF, 6'b010000}) $display("FAIL sub_cin: got %h want %h", outs, {16'h00FF, 6'b010000});
        else passed++;
        CIN = 1'b0;

        drive(1'b1, 4'd5, 8'h00, 8'h00, 2'b11); tick();
        total++;
        if (outs !== {16'h00FF, 6'b000000}) $display("FAIL dec_a_wrap: got %h want %h", outs, {16'h00FF, 6'b000000});
        else passed++;
    endtask

    task automatic test_sub_cmp();
        drive(1'b1, 4'd1, 8'h05, 8'h0A, 2'b11); tick();
        total++;
        if (outs !== {16'h00FB, 6'b010000}) $display("FAIL sub_borrow: got %h want %h", outs, {16'h00FB, 6'b010000});
        else passed++;

        drive(1'b1, 4'd8, 8'h33, 8'h33, 2'b11); tick();
        total++;
        if (outs !== {16'h0000, 6'b000010}) $display("FAIL cmp_eq: got %h want %h", outs, {16'h0000, 6'b000010});
        else passed++;

        drive(1'b1, 4'd8, 8'h40, 8'h30, 2'b11); tick();
        total++;
        if (outs !== {16'h0000, 6'b001000}) $display("FAIL cmp_gt: got %h want %h", outs, {16'h0000, 6'b001000});
        else passed++;
    endtask

    task automatic test_mul();
        // Previous outputs are the CMP greater-than result.
        drive(1'b1, 4'd9, 8'h03, 8'h04, 2'b11); tick();
        total++;
        if (outs !== {16'h0000, 6'b001000}) $display("FAIL mul_hold: got %h want %h", outs, {16'h0000, 6'b001000});
        else passed++;

        // Intermediate-edge inputs are ignored, not queued.
        drive(1'b1, 4'd0, 8'h01, 8'h01, 2'b11); tick();
        total++;
        if (outs !== {16'h0014, 6'b000000}) $display("FAIL mul_inc: got %h want %h", outs, {16'h0014, 6'b000000});
        else passed++;
        tick();
        total++;
        if (outs !== {16'h0002, 6'b000000}) $display("FAIL after_mul_add: got %h want %h", outs, {16'h0002, 6'b000000});
        else passed++;

        drive(1'b1, 4'd10, 8'h81, 8'h02, 2'b11); tick();
        total++;
        if (outs !== {16'h0002, 6'b000000}) $display("FAIL mul_shl_hold: got %h want %h", outs, {16'h0002, 6'b000000});
        else passed++;
        tick();
        total++;
        if (outs !== {16'h0004, 6'b000000}) $display("FAIL mul_shl: got %h want %h", outs, {16'h0004, 6'b000000});
        else passed++;

        // CE stall in the middle of a multiply.
        drive(1'b1, 4'd9, 8'h0F, 8'h0F, 2'b11); tick();
        CE = 1'b0;
        drive(1'b1, 4'd0, 8'h55, 8'h22, 2'b11); tick(); tick();
        total++;
        if (outs !== {16'h0004, 6'b000000}) $display("FAIL mul_stall: got %h want %h", outs, {16'h0004, 6'b000000});
        else passed++;
        CE = 1'b1; tick();
        total++;
        if (outs !== {16'h0100, 6'b000000}) $display("FAIL mul_resume: got %h want %h", outs, {16'h0100, 6'b000000});
        else passed++;
    endtask

    task automatic test_logic();
        drive(1'b0, 4'd1, 8'hF0, 8'hFF, 2'b11); tick();
        total++;
        if (outs !== {16'h000F, 6'b000000}) $display("FAIL nand: got %h want %h", outs, {16'h000F, 6'b000000});
        else passed++;

        drive(1'b0, 4'd12, 8'h81, 8'h01, 2'b11); tick();
        total++;
        if (outs !== {16'h0003, 6'b000000}) $display("FAIL rol: got %h want %h", outs, {16'h0003, 6'b000000});
        else passed++;

        drive(1'b0, 4'd13, 8'h81, 8'h10, 2'b11); tick();
        total++;
        if (outs !== {16'h0081, 6'b000001}) $display("FAIL ror_range: got %h want %h", outs, {16'h0081, 6'b000001});
        else passed++;

        drive(1'b0, 4'd9, 8'h81, 8'h00, 2'b01); tick();
        total++;
        if (outs !== {16'h0002, 6'b000000}) $display("FAIL shl1_a: got %h want %h", outs, {16'h0002, 6'b000000});
        else passed++;
    endtask

    task automatic test_validity();
        drive(1'b1, 4'd0, 8'h12, 8'h34, 2'b01); tick();
        total++;
        if (outs !== {16'h0000, 6'b000001}) $display("FAIL add_need_ab: got %h want %h", outs, {16'h0000, 6'b000001});
        else passed++;

        drive(1'b1, 4'd4, 8'hFF, 8'h00, 2'b01); tick();
        total++;
        if (outs !== {16'h0100, 6'b000000}) $display("FAIL inc_a_wrap: got %h want %h", outs, {16'h0100, 6'b000000});
        else passed++;

        drive(1'b1, 4'd6, 8'h00, 8'h07, 2'b01); tick();
        total++;
        if (outs !== {16'h0000, 6'b000001}) $display("FAIL inc_b_need_b: got %h want %h", outs, {16'h0000, 6'b000001});
        else passed++;

        drive(1'b0, 4'd15, 8'h12, 8'h34, 2'b11); tick();
        total++;
        if (outs !== {16'h0000, 6'b000001}) $display("FAIL illegal_cmd: got %h want %h", outs, {16'h0000, 6'b000001});
        else passed++;

        // Multiply with bad operands errors after one cycle.
        drive(1'b1, 4'd9, 8'h03, 8'h04, 2'b10); tick();
        total++;
        if (outs !== {16'h0000, 6'b000001}) $display("FAIL mul_err: got %h want %h", outs, {16'h0000, 6'b000001});
        else passed++;
    endtask

    task automatic test_ce_hold();
        drive(1'b1, 4'd0, 8'h01, 8'h02, 2'b11); tick();
        total++;
        if (outs !== {16'h0003, 6'b000000}) $display("FAIL ce_pre: got %h want %h", outs, {16'h0003, 6'b000000});
        else passed++;
        CE = 1'b0;
        drive(1'b0, 4'd2, 8'h10, 8'h0F, 2'b11); tick(); tick();
        total++;
        if (outs !== {16'h0003, 6'b000000}) $display("FAIL ce_hold: got %h want %h", outs, {16'h0003, 6'b000000});
        else passed++;
        CE = 1'b1;
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 4'd9, 8'h03, 8'h04, 2'b11); tick();
        RST = 1'b1; tick();
        total++;
        if (outs !== 22'h0) $display("FAIL reset_mid_mul: got %h want %h", outs, 22'h0);
        else passed++;
        RST = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 8'hFF, 2'b11); tick();
        total++;
        if (outs !== 22'h0) $display("FAIL no_late_product: got %h want %h", outs, 22'h0);
        else passed++;
    endtask

    initial begin
        RST = 1'b0; CE = 1'b0; CIN = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 2'b00);
        test_reset();
        test_arith();
        test_sub_cmp();
        test_mul();
        test_logic();
        test_validity();
        test_ce_hold();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
